// File: rtl/lnrv_icb_arbiter.sv
// N-to-1 ICB arbiter: round-robin command arbitration, grant hold across slave
// back-pressure and in-order response routing via an outstanding grant-index FIFO.
// Optional build macro: LNRV_ICB_ARB_FIXED_PRIO_EN (fixed priority, master 0 highest).
module lnrv_icb_arbiter #(
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ICB_COUNT  = 4,
  parameter int unsigned P_OTS_COUNT  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  // master side
  input  logic [P_ICB_COUNT-1:0]                mn_icb_cmd_vld,
  output logic [P_ICB_COUNT-1:0]                mn_icb_cmd_rdy,
  input  logic [P_ICB_COUNT-1:0]                mn_icb_cmd_write,
  input  logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]   mn_icb_cmd_addr,
  input  logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]   mn_icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8*P_ICB_COUNT-1:0] mn_icb_cmd_wstrb,
  input  logic [3*P_ICB_COUNT-1:0]              mn_icb_cmd_size,
  output logic [P_ICB_COUNT-1:0]                mn_icb_rsp_vld,
  input  logic [P_ICB_COUNT-1:0]                mn_icb_rsp_rdy,
  output logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]   mn_icb_rsp_rdata,
  output logic [P_ICB_COUNT-1:0]                mn_icb_rsp_err,
  // slave side
  output logic                                  s_icb_cmd_vld,
  input  logic                                  s_icb_cmd_rdy,
  output logic                                  s_icb_cmd_write,
  output logic [P_ADDR_WIDTH-1:0]               s_icb_cmd_addr,
  output logic [P_DATA_WIDTH-1:0]               s_icb_cmd_wdata,
  output logic [P_DATA_WIDTH/8-1:0]             s_icb_cmd_wstrb,
  output logic [2:0]                            s_icb_cmd_size,
  input  logic                                  s_icb_rsp_vld,
  output logic                                  s_icb_rsp_rdy,
  input  logic [P_DATA_WIDTH-1:0]               s_icb_rsp_rdata,
  input  logic                                  s_icb_rsp_err
);

  localparam int unsigned IdxW  = $clog2(P_ICB_COUNT);
  localparam int unsigned PtrW  = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
  // Storage rounded up to a power of two so pointers index it without width loss;
  // pointers still wrap at P_OTS_COUNT.
  localparam int unsigned FifoD = 1 << PtrW;
  localparam int unsigned CntW  = $clog2(P_OTS_COUNT + 1);
  localparam int unsigned StrbW = P_DATA_WIDTH / 8;

  logic [IdxW-1:0] fifo_q [FifoD];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold_q;
  logic [IdxW-1:0] hold_idx_q;

  logic            full, empty, push, pop;
  logic            arb_vld, gnt_req, gnt_vld;
  logic [IdxW-1:0] arb_idx, gnt_idx, head_idx;

  assign full  = (cnt_q == CntW'(P_OTS_COUNT));
  assign empty = (cnt_q == '0);
  assign push  = gnt_vld & s_icb_cmd_rdy;
  assign pop   = s_icb_rsp_vld & s_icb_rsp_rdy;

`ifdef LNRV_ICB_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int k = P_ICB_COUNT - 1; k >= 0; k--) begin
      if (mn_icb_cmd_vld[k]) begin
        arb_vld = 1'b1;
        arb_idx = IdxW'(k);
      end
    end
  end
`else
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] cand_idx;

  // Round-robin: first requester at or after rr_ptr, wrapping; descending scan so
  // the nearest candidate is written last.
  always_comb begin
    arb_vld  = 1'b0;
    arb_idx  = '0;
    cand_idx = '0;
    for (int k = P_ICB_COUNT - 1; k >= 0; k--) begin
      cand_idx = IdxW'((int'(rr_ptr_q) + k) % P_ICB_COUNT);
      if (mn_icb_cmd_vld[cand_idx]) begin
        arb_vld = 1'b1;
        arb_idx = cand_idx;
      end
    end
  end

  // Advance the pointer past the master whose command was accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (gnt_idx == IdxW'(P_ICB_COUNT - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // Grant selection: a live hold pins the grant; a dropped held request falls
  // back to normal arbitration. No grant while the FIFO is full.
  always_comb begin
    if (hold_q && mn_icb_cmd_vld[hold_idx_q]) begin
      gnt_req = 1'b1;
      gnt_idx = hold_idx_q;
    end else begin
      gnt_req = arb_vld;
      gnt_idx = arb_idx;
    end
    gnt_vld = gnt_req & ~full;
  end

  // Hold register: set while a presented command is back-pressured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= gnt_vld & ~s_icb_cmd_rdy;
      hold_idx_q <= gnt_idx;
    end
  end

  assign s_icb_cmd_vld   = gnt_vld;
  assign s_icb_cmd_write = mn_icb_cmd_write[gnt_idx];
  assign s_icb_cmd_addr  = mn_icb_cmd_addr[gnt_idx*P_ADDR_WIDTH +: P_ADDR_WIDTH];
  assign s_icb_cmd_wdata = mn_icb_cmd_wdata[gnt_idx*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign s_icb_cmd_wstrb = mn_icb_cmd_wstrb[gnt_idx*StrbW +: StrbW];
  assign s_icb_cmd_size  = mn_icb_cmd_size[gnt_idx*3 +: 3];

  // Only the granted master sees the slave ready.
  always_comb begin
    mn_icb_cmd_rdy = '0;
    if (gnt_vld && s_icb_cmd_rdy) mn_icb_cmd_rdy[gnt_idx] = 1'b1;
  end

  assign head_idx      = fifo_q[rd_ptr_q];
  assign s_icb_rsp_rdy = ~empty & mn_icb_rsp_rdy[head_idx];

  // Route the slave response to the FIFO head master; nothing routed when empty.
  always_comb begin
    mn_icb_rsp_vld   = '0;
    mn_icb_rsp_rdata = '0;
    mn_icb_rsp_err   = '0;
    if (!empty) begin
      mn_icb_rsp_vld[head_idx]                                = s_icb_rsp_vld;
      mn_icb_rsp_rdata[head_idx*P_DATA_WIDTH +: P_DATA_WIDTH] = s_icb_rsp_rdata;
      mn_icb_rsp_err[head_idx]                                = s_icb_rsp_err;
    end
  end

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and count; reset discards all outstanding entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(P_OTS_COUNT - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(P_OTS_COUNT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_idx;
  end

endmodule
